muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the ALU. It takes the same SrcA/SrcB operands from the operand muxes.
- Owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It drives hi/lo to the writeback mux for MFHI/MFLO.
- Raises busy so the controller stalls while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width. Fixed at 32 in this design; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request; Op and operands sampled at this edge
- Op  input  6  funct code: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO
- SrcA  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO data
- SrcB  input  32  rt operand: multiplier or divisor
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  high while an operation is in flight (state != IDLE)
- done  output  1  registered one-cycle pulse after HI/LO are updated by a MULT/DIV

Behaviour:
- Clock and reset: one clock is used (clk). Reset (rst) is synchronous and active-high. On reset: state=IDLE, count=0, hi=0, lo=0, done=0, busy=0. Reset has priority over every other input and aborts any in-flight operation; HI/LO are cleared.
- States:
  - IDLE: accepts requests.
  - CALC: exactly 32 iteration cycles.
  - FIX: one cycle of sign correction and HI/LO write.
- Accepting a request: start=1 in IDLE with a MULT/DIV code at edge k.
  - Latch SrcA, SrcB and Op.
  - Compute sign flags.
  - Load internal magnitudes. For signed ops these are the two's-complement absolute values; 0x80000000 stays 0x80000000 and is treated as unsigned.
  - Set count=0 and state=CALC.
- CALC, edges k+1..k+32: one iteration per edge; count increments. At the edge where count==31, go to FIX.
  - Multiply: 64-bit shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first. Remainder is a 33-bit working register.
- FIX, edge k+33:
  - Negate the 64-bit product if the operand signs differ (signed MULT only).
  - Negate the quotient if the operand signs differ; the remainder takes the dividend's sign (signed DIV only).
  - Write HI/LO, set state=IDLE, set done=1.
  - done returns to 0 at the next edge.
- Timing: busy is high for exactly 33 cycles, from the cycle after edge k through the cycle ending at edge k+33. New HI/LO values are visible from the cycle after edge k+33.
- Results:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (SrcB==0, signed or unsigned): the sign fix is bypassed. LO = 0xFFFFFFFF and HI = the latched SrcA. done and timing are unchanged (33 cycles).
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0x00000000.
- MTHI/MTLO: start=1 in IDLE with these codes writes SrcA to hi (MTHI) or lo (MTLO) at that edge. They take no busy cycle and produce no done pulse.
- Ignored requests:
  - start while busy=1, of any Op, is ignored. It does not restart the operation or corrupt it. The controller is required to stall instead.
  - start with an unlisted Op is ignored; state, HI and LO are unchanged.
- Stability: HI/LO hold their previous values for the whole CALC/FIX period. An MFHI issued under stall reads the old value until done.
- Back-to-back: a start in the cycle where done=1 (state is already IDLE) is accepted normally.

Test Plan:
- Unsigned multiply: reset 2 cycles, then MULTU SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> busy high 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- Signed multiply: MULT SrcA=0xFFFFFFF9 (-7), SrcB=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- Signed divide signs: DIV SrcA=0xFFFFFFF9 (-7), SrcB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU SrcA=100, SrcB=7 -> lo=14, hi=2.
- Divide by zero and overflow: DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Mid-operation interference: MTHI SrcA=0xA5A5A5A5 in IDLE -> hi updates next cycle, no busy. Then MULTU 5×6 followed by start=1 MTLO 0xDEAD at cycle 10 of busy -> MTLO ignored; final hi=0, lo=30.
- Reset mid-operation: rst=1 at cycle 15 of a DIV -> next cycle busy=0, hi=lo=0, done=0. A following MULTU 2×3 -> lo=6 after 33 busy cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: 32-cycle shift-add multiply,
// 32-cycle restoring divide, and a final sign-fix cycle that writes HI/LO.
//
// state | meaning
// IDLE  | accepts MULT/DIV/MTHI/MTLO requests
// CALC  | one multiply or divide iteration per cycle, 32 cycles
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam int         CW       = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc;     // product high half / partial remainder
    logic [WIDTH-1:0]   qr;      // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]   mc;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_lat;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic               req_signed;
    logic               neg_a_req;
    logic               neg_b_req;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign req_signed = ~Op[0];
    assign neg_a_req  = req_signed & SrcA[WIDTH-1];
    assign neg_b_req  = req_signed & SrcB[WIDTH-1];

    assign mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, mc} : '0);
    assign div_shift = {acc, qr[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mc};
    // when div_ge holds the difference is below the divisor, so it fits WIDTH bits
    assign div_rem   = div_shift[WIDTH-1:0] - mc;
    assign prod      = {acc, qr};
    assign prod_neg  = -prod;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            qr     <= '0;
            mc     <= '0;
            a_lat  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (Op)
                            OP_MTHI: hi <= SrcA;
                            OP_MTLO: lo <= SrcA;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div <= Op[1];
                                a_lat  <= SrcA;
                                div0   <= (SrcB == '0);
                                neg_q  <= neg_a_req ^ neg_b_req;
                                neg_r  <= neg_a_req;
                                mc     <= neg_b_req ? -SrcB : SrcB;
                                qr     <= neg_a_req ? -SrcA : SrcA;
                                acc    <= '0;
                                count  <= '0;
                                state  <= CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc <= div_ge ? div_rem : div_shift[WIDTH-1:0];
                        qr  <= {qr[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        qr  <= {mul_sum[0], qr[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        if (div0) begin
                            hi <= a_lat;
                            lo <= '1;
                        end else begin
                            hi <= neg_r ? -acc : acc;
                            lo <= neg_q ? -qr : qr;
                        end
                    end else begin
                        {hi, lo} <= neg_q ? prod_neg : prod;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: signed/unsigned mul/div, divide by zero,
// overflow, MTHI/MTLO, ignored requests and reset mid-operation.
module tb_muldiv_unit;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Op    (Op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op at the next edge and follow it to completion. An extra start
    // can be injected at busy cycle inj_cyc to confirm it is ignored.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int inj_cyc,
                          input logic [5:0] inj_op, input logic [31:0] inj_a);
        int          nbusy;
        int          unstable;
        int          early_done;
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = hi;
        lo0 = lo;
        nbusy = 0;
        unstable = 0;
        early_done = 0;
        Op = op; SrcA = a; SrcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && nbusy < 200) begin
            nbusy++;
            if (hi !== hi0 || lo !== lo0) unstable++;
            if (done) early_done++;
            if (nbusy == inj_cyc) begin
                Op = inj_op; SrcA = inj_a; SrcB = 32'd0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'd33);
        chk({tag, " hold"}, 32'(unstable + early_done), 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        @(negedge clk);
        chk({tag, " done_clear"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; Op = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 0, '0, '0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFF9, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, '0, '0);
        run_op("mult_2neg", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
               32'h0000_0000, 32'h0000_0006, 0, '0, '0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, '0, '0);
        run_op("div_negdivisor", OP_DIV, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 0, '0, '0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, '0, '0);
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0,
               32'h0000_1234, 32'hFFFF_FFFF, 0, '0, '0);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF0, 32'd0,
               32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, '0, '0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 0, '0, '0);

        Op = OP_MTHI; SrcA = 32'hA5A5_A5A5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mthi hi", hi, 32'hA5A5_A5A5);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("mthi done", {31'd0, done}, 32'd0);

        Op = 6'b100000; SrcA = 32'h1111_1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("badop busy", {31'd0, busy}, 32'd0);
        chk("badop hi", hi, 32'hA5A5_A5A5);
        chk("badop lo", lo, 32'h8000_0000);

        run_op("multu_inj", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30,
               10, OP_MTLO, 32'h0000_DEAD);

        // back-to-back: start issued in the cycle done is high
        Op = OP_DIVU; SrcA = 32'd50; SrcB = 32'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && !done) @(negedge clk);
        Op = OP_MULTU; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
        chk("b2b done", {31'd0, done}, 32'd1);
        chk("b2b div lo", lo, 32'd6);
        @(negedge clk);
        start = 1'b0;
        chk("b2b accepted", {31'd0, busy}, 32'd1);
        repeat (40) @(negedge clk);
        chk("b2b mul lo", lo, 32'd81);

        Op = OP_DIV; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid busy", {31'd0, busy}, 32'd0);
        chk("rst_mid hi", hi, 32'd0);
        chk("rst_mid lo", lo, 32'd0);
        chk("rst_mid done", {31'd0, done}, 32'd0);
        run_op("multu_after_rst", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
